// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a framed little-endian byte stream,
// writes assembled 32-bit words to memory_32 and holds the CPU until a good checksum.
module imem_loader #(
   parameter int                ADDR_W      = 64,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int                DEPTH_WORDS = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              start,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err
);

   localparam logic [2:0] S_HDR0 = 3'd0;
   localparam logic [2:0] S_HDR1 = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
   localparam logic [2:0] S_CHK  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
   localparam logic [2:0] S_ERR  = 3'd5;

   // Header counts above this limit are rejected before any write is issued.
   localparam logic [16:0] DEPTH_LIM = 17'(DEPTH_WORDS);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_req_t;

   logic [2:0]  state, nxt;
   logic [7:0]  cnt_lo;
   logic [15:0] cnt;
   logic [1:0]  bidx;
   logic [15:0] widx;
   logic [23:0] asm_q;
   logic [7:0]  xsum;
   wr_req_t     wr_q;

   logic        xfer;
   logic [15:0] hdr_cnt;
   logic        word_done;
   logic        last_word;
   logic        rearm;

   assign xfer      = in_valid & in_ready;
   assign hdr_cnt   = {in_data, cnt_lo};
   assign word_done = (state == S_DATA) && xfer && (bidx == 2'd3);
   assign last_word = (widx == cnt - 16'd1);
   assign rearm     = start && ((state == S_DONE) || (state == S_ERR));

   assign mem_addr  = wr_q.addr;
   assign mem_wdata = wr_q.data;

   always_comb begin
      nxt = state;
      case (state)
         S_HDR0: if (xfer) nxt = S_HDR1;
         S_HDR1: begin
            if (xfer) begin
               if (hdr_cnt == 16'd0)                  nxt = S_CHK;
               else if ({1'b0, hdr_cnt} > DEPTH_LIM)  nxt = S_ERR;
               else                                   nxt = S_DATA;
            end
         end
         S_DATA: if (word_done && last_word) nxt = S_CHK;
         S_CHK:  if (xfer) nxt = (in_data == xsum) ? S_DONE : S_ERR;
         S_DONE: if (start) nxt = S_HDR0;
         S_ERR:  if (start) nxt = S_HDR0;
         default: nxt = S_HDR0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_HDR0;
         in_ready  <= 1'b0;
         mem_wr_en <= 1'b0;
         wr_q      <= '0;
         cpu_hold  <= 1'b1;
         load_done <= 1'b0;
         load_err  <= 1'b0;
         cnt_lo    <= '0;
         cnt       <= '0;
         bidx      <= '0;
         widx      <= '0;
         asm_q     <= '0;
         xsum      <= '0;
      end else begin
         state     <= nxt;
         in_ready  <= (nxt == S_HDR0) || (nxt == S_HDR1) || (nxt == S_DATA) || (nxt == S_CHK);
         mem_wr_en <= word_done;
         load_done <= (state == S_CHK) && (nxt == S_DONE);

         if ((state == S_CHK) && (nxt == S_DONE))
            cpu_hold <= 1'b0;
         if ((nxt == S_ERR) && (state != S_ERR))
            load_err <= 1'b1;

         if ((state == S_HDR0) && xfer)
            cnt_lo <= in_data;
         if ((state == S_HDR1) && xfer)
            cnt <= hdr_cnt;

         if ((state == S_DATA) && xfer) begin
            bidx <= bidx + 2'd1;
            xsum <= xsum ^ in_data;
            case (bidx)
               2'd0:    asm_q[7:0]   <= in_data;
               2'd1:    asm_q[15:8]  <= in_data;
               2'd2:    asm_q[23:16] <= in_data;
               default: asm_q        <= asm_q;
            endcase
         end

         // Address/data only move on a completed word; they hold between strobes.
         if (word_done) begin
            wr_q.addr <= BASE_ADDR + (ADDR_W'(widx) << 2);
            wr_q.data <= {in_data, asm_q};
            widx      <= widx + 16'd1;
         end

         if (rearm) begin
            cpu_hold <= 1'b1;
            load_err <= 1'b0;
            cnt_lo   <= '0;
            cnt      <= '0;
            bidx     <= '0;
            widx     <= '0;
            asm_q    <= '0;
            xsum     <= '0;
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: frames are built from word lists and the expected
// writes/outcome are derived directly from the frame rules.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        start = 1'b0;
   logic        in_ready;
   logic        mem_wr_en;
   logic [63:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_hold;
   logic        load_done;
   logic        load_err;

   imem_loader dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .start(start), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [63:0] cap_a[$];
   logic [31:0] cap_d[$];
   int  dbl = 0;
   int  done_cnt = 0;
   int  done_hold_bad = 0;
   bit  prev_wr = 1'b0;
   bit  prev_done = 1'b0;

   always @(negedge clk) begin
      if (mem_wr_en) begin
         cap_a.push_back(mem_addr);
         cap_d.push_back(mem_wdata);
         if (prev_wr) dbl++;
      end
      if (load_done) begin
         done_cnt++;
         if (cpu_hold) done_hold_bad++;
         if (prev_done) dbl++;
      end
      prev_wr   = mem_wr_en;
      prev_done = load_done;
   end

   logic [31:0] wq[$];

   task automatic clear_caps();
      cap_a.delete();
      cap_d.delete();
      dbl = 0;
      done_cnt = 0;
      done_hold_bad = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      repeat ($urandom_range(0, gap)) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      t = 0;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         chk("byte_timeout", 64'd0, 64'd1);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         in_data  = 8'($urandom);
      end
   endtask

   // Sends a full frame of n words from wq and checks writes and outcome against the frame rules.
   task automatic run_frame(input int n, input bit badc, input int gap);
      logic [7:0] x;
      logic [7:0] cbyte;
      bit ok;
      int nexp;
      x = 8'h00;
      clear_caps();
      send_byte(n[7:0], gap);
      send_byte(n[15:8], gap);
      if (n <= 64) begin
         for (int i = 0; i < n; i++)
            for (int j = 0; j < 4; j++) begin
               send_byte(wq[i][8*j +: 8], gap);
               x ^= wq[i][8*j +: 8];
            end
         chk("hold_mid", cpu_hold, 1);
         cbyte = badc ? (x ^ 8'($urandom_range(1, 255))) : x;
         send_byte(cbyte, gap);
      end
      repeat (3) @(negedge clk);
      ok   = (n <= 64) && !badc;
      nexp = (n <= 64) ? n : 0;
      chk("n_writes", cap_a.size(), nexp);
      for (int i = 0; i < cap_a.size() && i < nexp; i++) begin
         chk("wr_addr", cap_a[i], 64'(4 * i));
         chk("wr_data", cap_d[i], wq[i]);
      end
      chk("strobe_1cyc", dbl, 0);
      chk("done_pulses", done_cnt, ok ? 1 : 0);
      chk("hold_at_done", done_hold_bad, 0);
      chk("cpu_hold", cpu_hold, !ok);
      chk("load_err", load_err, !ok);
      chk("ready_idle", in_ready, 0);
      chk("wr_idle", mem_wr_en, 0);
   endtask

   task automatic rearm();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk("rearm_ready", in_ready, 1);
      chk("rearm_hold", cpu_hold, 1);
      chk("rearm_err", load_err, 0);
   endtask

   task automatic rand_words(input int n);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ready", in_ready, 0);
      chk("rst_wr", mem_wr_en, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_hold", cpu_hold, 1);
      chk("rst_done", load_done, 0);
      chk("rst_err", load_err, 0);
      reset = 1'b0;
      chk("post_rst_ready", in_ready, 0);

      wq.delete(); wq.push_back(32'h00500093);
      run_frame(1, 1'b0, 0);

      rearm();
      wq.delete();
      run_frame(0, 1'b0, 2);

      rearm();
      wq.delete(); wq.push_back(32'h00500093);
      run_frame(1, 1'b1, 0);
      rearm();
      run_frame(1, 1'b0, 1);

      rearm();
      run_frame(65, 1'b0, 0);

      rearm();
      rand_words(3);
      run_frame(3, 1'b0, 4);

      // Reset in the middle of word 1: only word 0 may reach memory.
      rearm();
      rand_words(2);
      clear_caps();
      send_byte(8'd2, 0);
      send_byte(8'd0, 0);
      for (int j = 0; j < 4; j++) send_byte(wq[0][8*j +: 8], 1);
      send_byte(wq[1][7:0], 0);
      send_byte(wq[1][15:8], 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("partial_writes", cap_a.size(), 1);
      if (cap_a.size() > 0) chk("partial_addr0", cap_a[0], 64'd0);
      chk("partial_hold", cpu_hold, 1);
      rand_words(1);
      run_frame(1, 1'b0, 1);

      rearm();
      rand_words(64);
      run_frame(64, 1'b0, 0);

      for (int k = 0; k < 6; k++) begin
         int n;
         n = $urandom_range(1, 10);
         rearm();
         rand_words(n);
         run_frame(n, ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
